systolic_host_sequencer: RTL and testbench

Host-side initiator for the systolic-array multiplier pin interface. It accepts an operand nibble stream (N×N weights, then N×N inputs) on a valid/ready port, and drives the array's `load_weights`, `load_inputs` and `store_outputs` strobes with the nibble data. It then collects the N×N `valid_out`-qualified results into a result FIFO that is drained over a second valid/ready port. It sits between a test/host controller (or the chip-level pin mux) and the array's `data_in`/`results` pins.

---
 rtl/systolic_host_sequencer.sv | 154 +++++++++++++++
 tb/tb_systolic_host_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_host_sequencer.sv
// Host-side sequencer for the systolic-array pin interface: streams weights and
// inputs onto the array strobes, fires store_outputs, then buffers the results.
`timescale 1ns/1ps
module systolic_host_sequencer #(
  parameter int BITWIDTH = 4,
  parameter int OUTWIDTH = 2 * BITWIDTH,
  parameter int N        = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [BITWIDTH-1:0] op_data,
  output logic [BITWIDTH-1:0] arr_data,
  output logic                arr_load_weights,
  output logic                arr_load_inputs,
  output logic                arr_store_outputs,
  input  logic [OUTWIDTH-1:0] arr_results,
  input  logic                arr_valid_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OUTWIDTH-1:0] res_data,
  output logic                busy,
  output logic                err_timeout
);

  localparam int NN    = N * N;
  localparam int CNT_W = $clog2(NN + 1);
  localparam int PTR_W = (NN > 1) ? $clog2(NN) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NN - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NN - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, STORE, COLLECT, DRAIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    nib_cnt;
  logic [CNT_W-1:0]    res_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [OUTWIDTH-1:0] fifo_mem [NN];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                op_fire;
  logic                push;
  logic                pop;

  // Handshakes: a transfer happens on any rising edge where valid & ready are both 1.
  assign op_ready  = (state == IDLE) || (state == LOAD_W) || (state == LOAD_I);
  assign op_fire   = op_valid & op_ready;
  assign push      = (state == COLLECT) & arr_valid_out;
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid & res_ready;
  assign res_data  = res_valid ? fifo_mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      arr_data          <= '0;
      arr_load_weights  <= 1'b0;
      arr_load_inputs   <= 1'b0;
      arr_store_outputs <= 1'b0;
      err_timeout       <= 1'b0;
      nib_cnt           <= '0;
      res_cnt           <= '0;
      tmo_cnt           <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted by a fresh handshake.
      arr_load_weights  <= 1'b0;
      arr_load_inputs   <= 1'b0;
      arr_store_outputs <= 1'b0;
      err_timeout       <= 1'b0;
      case (state)
        IDLE: begin
          if (op_fire) begin
            arr_data         <= op_data;
            arr_load_weights <= 1'b1;
            nib_cnt          <= CNT_W'(1);
            state            <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (op_fire) begin
            arr_data         <= op_data;
            arr_load_weights <= 1'b1;
            if (nib_cnt == LAST_CNT) begin
              nib_cnt <= '0;
              state   <= LOAD_I;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (op_fire) begin
            arr_data        <= op_data;
            arr_load_inputs <= 1'b1;
            if (nib_cnt == LAST_CNT) begin
              nib_cnt <= '0;
              state   <= STORE;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
        end
        STORE: begin
          arr_store_outputs <= 1'b1;
          res_cnt           <= '0;
          tmo_cnt           <= '0;
          state             <= COLLECT;
        end
        COLLECT: begin
          if (arr_valid_out) begin
            res_cnt <= res_cnt + 1'b1;
            tmo_cnt <= '0;
            if (res_cnt == LAST_CNT) state <= DRAIN;
          end else if (tmo_cnt == LAST_TMO) begin
            // Give up on the missing results; whatever was captured still drains.
            err_timeout <= 1'b1;
            state       <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!res_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= arr_results;
  end

  // Depth equals one transaction's result count, so a push never finds the FIFO full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_host_sequencer.sv
// Directed bench for systolic_host_sequencer with a behavioural 2x2 array model.
`timescale 1ns/1ps
module tb_systolic_host_sequencer;

  localparam int BW  = 4;
  localparam int OW  = 8;
  localparam int N   = 2;
  localparam int NN  = N * N;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [BW-1:0] op_data = '0;
  logic [BW-1:0] arr_data;
  logic          arr_load_weights;
  logic          arr_load_inputs;
  logic          arr_store_outputs;
  logic [OW-1:0] arr_results;
  logic          arr_valid_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_data;
  logic          busy;
  logic          err_timeout;

  logic          model_valid = 1'b0;
  logic          stray_valid = 1'b0;
  logic [OW-1:0] model_res = '0;
  assign arr_valid_out = model_valid | stray_valid;
  assign arr_results   = model_res;

  systolic_host_sequencer #(.BITWIDTH(BW), .OUTWIDTH(OW), .N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .arr_data(arr_data), .arr_load_weights(arr_load_weights),
    .arr_load_inputs(arr_load_inputs), .arr_store_outputs(arr_store_outputs),
    .arr_results(arr_results), .arr_valid_out(arr_valid_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- array model and monitor ----------------
  logic [BW-1:0] w_log[$];
  logic [BW-1:0] i_log[$];
  logic [OW-1:0] r_log[$];
  logic [OW-1:0] emit_q[$];
  int            w_cyc[$];
  int            i_cyc[$];
  int            s_cyc[$];
  int            e_cyc[$];
  int            excl_viol = 0;
  int            last_cap = 0;
  bit            timeout_mode = 1'b0;
  logic [BW-1:0] mw[NN];
  logic [BW-1:0] mi[NN];
  int            wn = 0;
  int            in_n = 0;
  int            delay = -1;

  always @(negedge clk) begin
    model_valid = 1'b0;
    if (!rst_n) begin
      wn = 0;
      in_n = 0;
      delay = -1;
      emit_q.delete();
    end else begin
      if (int'(arr_load_weights) + int'(arr_load_inputs) + int'(arr_store_outputs) > 1)
        excl_viol++;
      if (arr_load_weights) begin
        w_log.push_back(arr_data);
        w_cyc.push_back(cyc);
        if (wn < NN) mw[wn] = arr_data;
        wn++;
      end
      if (arr_load_inputs) begin
        i_log.push_back(arr_data);
        i_cyc.push_back(cyc);
        if (in_n < NN) mi[in_n] = arr_data;
        in_n++;
      end
      if (arr_store_outputs) begin
        s_cyc.push_back(cyc);
        if (timeout_mode) begin
          emit_q.push_back(8'd7);
          emit_q.push_back(8'd9);
        end else begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              int acc;
              acc = 0;
              for (int k = 0; k < N; k++) acc += int'(mw[r*N+k]) * int'(mi[k*N+c]);
              emit_q.push_back(acc[OW-1:0]);
            end
          end
        end
        wn = 0;
        in_n = 0;
        delay = 3;
      end
      if (err_timeout) e_cyc.push_back(cyc);
      if (res_valid && res_ready) r_log.push_back(res_data);
      if (delay > 0) delay--;
      if (delay == 0 && emit_q.size() > 0) begin
        model_valid = 1'b1;
        model_res = emit_q.pop_front();
        last_cap = cyc + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag, input int rb);
    int n;
    n = exp_q.size();
    chk({tag, "_rcnt"}, r_log.size() - rb, n);
    for (int k = 0; k < n; k++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      if (rb + k < r_log.size()) chk({tag, "_res"}, int'(r_log[rb+k]), int'(e));
    end
  endtask

  task automatic check_loads(input string tag, input int wb, input int ib, input int sb, input int step);
    chk({tag, "_wcnt"}, w_log.size() - wb, NN);
    chk({tag, "_icnt"}, i_log.size() - ib, NN);
    chk({tag, "_scnt"}, s_cyc.size() - sb, 1);
    if (w_log.size() - wb == NN && i_log.size() - ib == NN && s_cyc.size() - sb == 1) begin
      for (int k = 0; k < NN; k++) begin
        chk({tag, "_wdat"}, int'(w_log[wb+k]), k + 1);
        chk({tag, "_wcyc"}, w_cyc[wb+k] - w_cyc[wb], step * k);
        chk({tag, "_idat"}, int'(i_log[ib+k]), NN + k + 1);
        chk({tag, "_icyc"}, i_cyc[ib+k] - w_cyc[wb], step * (NN + k));
      end
      chk({tag, "_scyc"}, s_cyc[sb] - i_cyc[ib+NN-1], 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [BW-1:0] d);
    int n;
    n = 0;
    op_valid = 1'b1;
    op_data = d;
    while (!op_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("op_ready_wait", int'(op_ready), 1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic send_seq(input int first, input int count, input bit gap);
    for (int v = first; v < first + count; v++) begin
      send_op(BW'(v));
      if (gap) tick();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(busy), 0);
  endtask

  task automatic push_std();
    exp_q.push_back(8'd19);
    exp_q.push_back(8'd22);
    exp_q.push_back(8'd43);
    exp_q.push_back(8'd50);
  endtask

  // ---------------- tests ----------------
  initial begin
    int wb, ib, sb, rb, eb;

    // reset state
    #12;
    chk("rst_arr_data", int'(arr_data), 0);
    chk("rst_strobes", int'({arr_load_weights, arr_load_inputs, arr_store_outputs}), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_timeout), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_op_ready", int'(op_ready), 1);

    // stray valid_out in IDLE
    stray_valid = 1'b1;
    tick();
    tick();
    stray_valid = 1'b0;
    tick();
    chk("stray_idle_res_valid", int'(res_valid), 0);
    chk("stray_idle_busy", int'(busy), 0);

    // basic transaction, continuous operands
    res_ready = 1'b1;
    wb = w_log.size(); ib = i_log.size(); sb = s_cyc.size(); rb = r_log.size();
    send_seq(1, 2 * NN, 1'b0);
    wait_idle("basic_idle", 100);
    check_loads("basic", wb, ib, sb, 1);
    push_std();
    check_results("basic", rb);
    chk("basic_op_ready", int'(op_ready), 1);

    // gapped operands
    wb = w_log.size(); ib = i_log.size(); sb = s_cyc.size(); rb = r_log.size();
    send_seq(1, 2 * NN, 1'b1);
    wait_idle("gap_idle", 100);
    check_loads("gap", wb, ib, sb, 2);
    push_std();
    check_results("gap", rb);

    // backpressure on the result port
    res_ready = 1'b0;
    rb = r_log.size();
    send_seq(1, 2 * NN, 1'b0);
    repeat (15) tick();
    chk("bp_res_valid", int'(res_valid), 1);
    chk("bp_head", int'(res_data), 19);
    chk("bp_op_ready", int'(op_ready), 0);
    chk("bp_busy", int'(busy), 1);
    chk("bp_no_pop", r_log.size() - rb, 0);
    res_ready = 1'b1;
    wait_idle("bp_idle", 50);
    push_std();
    check_results("bp", rb);
    chk("bp_op_ready_after", int'(op_ready), 1);

    // collect timeout with only two results
    timeout_mode = 1'b1;
    rb = r_log.size(); eb = e_cyc.size();
    send_seq(1, 2 * NN, 1'b0);
    wait_idle("to_idle", 300);
    timeout_mode = 1'b0;
    chk("to_pulses", e_cyc.size() - eb, 1);
    if (e_cyc.size() - eb == 1) chk("to_delay", e_cyc[eb] - last_cap, TMO);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd9);
    check_results("to", rb);

    // async reset after three input nibbles
    send_seq(1, NN + 3, 1'b0);
    chk("arst_pre_load_i", int'(arr_load_inputs), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", int'({arr_load_weights, arr_load_inputs, arr_store_outputs}), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_arr_data", int'(arr_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    wb = w_log.size(); ib = i_log.size(); sb = s_cyc.size(); rb = r_log.size();
    send_seq(1, 2 * NN, 1'b0);
    wait_idle("arst_idle", 100);
    check_loads("arst", wb, ib, sb, 1);
    push_std();
    check_results("arst", rb);

    // stray valid_out during LOAD_W
    rb = r_log.size();
    send_seq(1, 1, 1'b0);
    stray_valid = 1'b1;
    tick();
    tick();
    stray_valid = 1'b0;
    tick();
    chk("stray_lw_res_valid", int'(res_valid), 0);
    chk("stray_lw_busy", int'(busy), 1);
    send_seq(2, 2 * NN - 1, 1'b0);
    wait_idle("stray_lw_idle", 100);
    push_std();
    check_results("stray_lw", rb);

    chk("strobe_excl", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
